// File: rtl/packet_assembler_pkg.sv
// Shared types and CRC-8 helpers for the packet assembler.
// CRC-8: polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR.
package packet_assembler_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StCheckCrc,
        StPresent
    } pa_state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc8_byte_update.sv
// Byte-serial CRC-8 accumulator; clear has priority over a same-cycle valid byte.
module crc8_byte_update (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [7:0] data,
    input  logic       valid,
    output logic [7:0] crc
);
    import packet_assembler_pkg::*;

    logic [7:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = CRC8_INIT;
        end else if (valid) begin
            crc_d = crc8_update(crc_q, data);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_q <= CRC8_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/packet_assembler.sv
// Assembles UART bytes into a message, checks a trailing CRC-8 and presents it with a handshake.
// Optional inter-byte timeout enabled by defining PACKET_ASSEMBLER_TIMEOUT_EN.
module packet_assembler #(
    parameter int unsigned DATA_LENGTH    = 8,
    parameter int unsigned MESSAGE_LENGTH = 48,
    parameter int unsigned CRC_LENGTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_LENGTH-1:0]    rx_data,
    input  logic                      rx_valid,
    output logic [MESSAGE_LENGTH-1:0] msg_data,
    output logic                      msg_valid,
    input  logic                      msg_ready,
    output logic                      crc_error,
    output logic                      overrun
);
    import packet_assembler_pkg::*;

    localparam int unsigned SEGMENT_COUNT = MESSAGE_LENGTH / DATA_LENGTH;
    localparam int unsigned SEG_W         = $clog2(SEGMENT_COUNT + 1);

    pa_state_e                 state_q, state_d;
    logic [SEG_W-1:0]          seg_cnt_q, seg_cnt_d;
    logic [MESSAGE_LENGTH-1:0] msg_data_q, msg_data_d;
    logic                      crc_error_q, crc_error_d;
    logic                      overrun_q, overrun_d;
    logic                      crc_clear, crc_valid;
    logic [CRC_LENGTH-1:0]     crc_value;
    logic                      timeout;

    crc8_byte_update u_crc (
        .clk   (clk),
        .reset (reset),
        .clear (crc_clear),
        .data  (rx_data),
        .valid (crc_valid),
        .crc   (crc_value)
    );

`ifdef PACKET_ASSEMBLER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            waiting;

    assign waiting = (state_q == StCollect) || (state_q == StCheckCrc);
    // Fires on the TIMEOUT_CYCLES-th consecutive cycle without a byte.
    assign timeout = waiting && !rx_valid && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        to_cnt_d = '0;
        if (waiting && !rx_valid && !timeout) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        seg_cnt_d   = seg_cnt_q;
        msg_data_d  = msg_data_q;
        crc_error_d = crc_error_q;
        overrun_d   = 1'b0;
        crc_clear   = 1'b0;
        crc_valid   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    msg_data_d[DATA_LENGTH-1:0] = rx_data;
                    seg_cnt_d = SEG_W'(1);
                    crc_valid = 1'b1;
                    state_d   = (SEGMENT_COUNT == 1) ? StCheckCrc : StCollect;
                end
            end
            StCollect: begin
                if (rx_valid) begin
                    for (int unsigned i = 0; i < SEGMENT_COUNT; i++) begin
                        if (seg_cnt_q == SEG_W'(i)) begin
                            msg_data_d[i*DATA_LENGTH +: DATA_LENGTH] = rx_data;
                        end
                    end
                    seg_cnt_d = seg_cnt_q + SEG_W'(1);
                    crc_valid = 1'b1;
                    if (seg_cnt_q == SEG_W'(SEGMENT_COUNT - 1)) begin
                        state_d = StCheckCrc;
                    end
                end else if (timeout) begin
                    state_d    = StIdle;
                    seg_cnt_d  = '0;
                    msg_data_d = '0;
                    crc_clear  = 1'b1;
                end
            end
            StCheckCrc: begin
                if (rx_valid) begin
                    crc_error_d = (rx_data[CRC_LENGTH-1:0] != crc_value);
                    state_d     = StPresent;
                end else if (timeout) begin
                    state_d    = StIdle;
                    seg_cnt_d  = '0;
                    msg_data_d = '0;
                    crc_clear  = 1'b1;
                end
            end
            StPresent: begin
                // Any byte here is dropped, including on the accepting cycle.
                overrun_d = rx_valid;
                if (msg_ready) begin
                    state_d     = StIdle;
                    seg_cnt_d   = '0;
                    crc_error_d = 1'b0;
                    crc_clear   = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            seg_cnt_q   <= '0;
            msg_data_q  <= '0;
            crc_error_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            seg_cnt_q   <= seg_cnt_d;
            msg_data_q  <= msg_data_d;
            crc_error_q <= crc_error_d;
            overrun_q   <= overrun_d;
        end
    end

    assign msg_data  = msg_data_q;
    assign msg_valid = (state_q == StPresent);
    assign crc_error = crc_error_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_packet_assembler.sv
// Self-checking bench for packet_assembler; reference CRC computed by polynomial long division.
module tb_packet_assembler;

    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [47:0] msg_data;
    logic        msg_valid;
    logic        msg_ready;
    logic        crc_error;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int ovr_cnt  = 0;

    always #5 clk = ~clk;

    packet_assembler #(
        .DATA_LENGTH    (8),
        .MESSAGE_LENGTH (48),
        .CRC_LENGTH     (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .msg_data  (msg_data),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .crc_error (crc_error),
        .overrun   (overrun)
    );

    always @(negedge clk) if (overrun === 1'b1) ovr_cnt++;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Remainder of M(x)*x^8 divided by x^8+x^2+x+1.
    function automatic logic [7:0] ref_crc(input logic [7:0] bytes [$]);
        logic [8:0] r;
        r = '0;
        foreach (bytes[k]) begin
            for (int b = 7; b >= 0; b--) begin
                r = {r[7:0], bytes[k][b]};
                if (r[8]) r = r ^ 9'h107;
            end
        end
        for (int b = 0; b < 8; b++) begin
            r = {r[7:0], 1'b0};
            if (r[8]) r = r ^ 9'h107;
        end
        return r[7:0];
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_packet(input logic [7:0] bytes [$], input logic [7:0] crc, input int max_gap);
        foreach (bytes[k]) begin
            send_byte(bytes[k]);
            idle($urandom_range(max_gap, 0));
        end
        send_byte(crc);
    endtask

    task automatic expect_msg(input string tag, input logic [7:0] bytes [$], input logic [7:0] crc);
        logic [47:0] d;
        d = '0;
        foreach (bytes[k]) d[k*8 +: 8] = bytes[k];
        check_eq({tag, "_valid"}, msg_valid, 1'b1);
        check_eq({tag, "_data"}, msg_data, d);
        check_eq({tag, "_crcerr"}, crc_error, crc != ref_crc(bytes));
    endtask

    task automatic accept();
        msg_ready = 1'b1;
        @(negedge clk);
        msg_ready = 1'b0;
        check_eq("accept_clears_valid", msg_valid, 1'b0);
    endtask

    initial begin
        logic [7:0]  q [$];
        logic [7:0]  c;
        logic [47:0] held_data;
        logic        held_err;
        logic        stable;
        logic        saw_valid;
        int          base;
        int          hold;
        int          extra;

        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        msg_ready = 1'b0;
        idle(3);
        check_eq("rst_msg_data", msg_data, 48'h0);
        check_eq("rst_msg_valid", msg_valid, 1'b0);
        check_eq("rst_crc_error", crc_error, 1'b0);
        check_eq("rst_overrun", overrun, 1'b0);
        reset = 1'b0;
        idle(1);

        // All-zero packet with zero CRC.
        q = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_packet(q, 8'h00, 0);
        expect_msg("zero", q, 8'h00);
        check_eq("zero_err_const", crc_error, 1'b0);
        accept();

        // Incrementing bytes, good then corrupted CRC.
        q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        c = ref_crc(q);
        send_packet(q, c, 0);
        check_eq("inc_data_const", msg_data, 48'h060504030201);
        check_eq("inc_good_crc", crc_error, 1'b0);
        accept();
        send_packet(q, c ^ 8'h01, 2);
        check_eq("inc_bad_valid", msg_valid, 1'b1);
        check_eq("inc_bad_crc", crc_error, 1'b1);
        accept();

        // Hold for 20 cycles with a stray byte in the middle.
        q.delete();
        repeat (6) q.push_back(8'($urandom));
        c = ref_crc(q);
        send_packet(q, c, 1);
        expect_msg("hold", q, c);
        base      = ovr_cnt;
        held_data = msg_data;
        held_err  = crc_error;
        stable    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) send_byte(8'hAA);
            else @(negedge clk);
            if (msg_valid !== 1'b1 || msg_data !== held_data || crc_error !== held_err) stable = 1'b0;
        end
        check_eq("hold_stable", stable, 1'b1);
        accept();
        idle(1);
        check_eq("hold_overrun_pulses", ovr_cnt - base, 1);

        // Byte arriving on the accepting cycle is dropped.
        q.delete();
        repeat (6) q.push_back(8'($urandom));
        c = ref_crc(q);
        send_packet(q, c, 0);
        base      = ovr_cnt;
        msg_ready = 1'b1;
        rx_valid  = 1'b1;
        rx_data   = 8'h55;
        @(negedge clk);
        msg_ready = 1'b0;
        rx_valid  = 1'b0;
        check_eq("acc_ovr_valid", msg_valid, 1'b0);
        idle(1);
        check_eq("acc_ovr_pulses", ovr_cnt - base, 1);
        q.delete();
        repeat (6) q.push_back(8'($urandom));
        c = ref_crc(q);
        send_packet(q, c, 0);
        expect_msg("after_drop", q, c);
        accept();

        // Reset mid-packet discards partial data.
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        reset = 1'b1;
        idle(1);
        check_eq("midrst_data", msg_data, 48'h0);
        reset = 1'b0;
        idle(1);
        q = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_packet(q, 8'h00, 0);
        check_eq("midrst_pkt_data", msg_data, 48'h0);
        check_eq("midrst_pkt_err", crc_error, 1'b0);
        accept();

        // Randomized packets against the reference model.
        for (int p = 0; p < 16; p++) begin
            q.delete();
            repeat (6) q.push_back(8'($urandom));
            c = ref_crc(q);
            if ($urandom_range(3, 0) == 0) c = c ^ 8'($urandom_range(255, 1));
            send_packet(q, c, 3);
            expect_msg("rand", q, c);
            hold  = $urandom_range(4, 0);
            extra = $urandom_range(1, 0);
            base  = ovr_cnt;
            for (int i = 0; i < hold; i++) begin
                if (extra == 1 && i == 0) send_byte(8'($urandom));
                else @(negedge clk);
            end
            accept();
            idle(1);
            check_eq("rand_overrun", ovr_cnt - base, (extra == 1 && hold > 0) ? 1 : 0);
        end

        // Stalled partial packet followed by a zero packet.
        base = ovr_cnt;
        send_byte(8'h12);
        send_byte(8'h34);
        saw_valid = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (msg_valid === 1'b1) saw_valid = 1'b1;
        end
        check_eq("stall_no_valid", saw_valid, 1'b0);
        repeat (7) send_byte(8'h00);
`ifdef PACKET_ASSEMBLER_TIMEOUT_EN
        q = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        expect_msg("stall", q, 8'h00);
        check_eq("stall_err_const", crc_error, 1'b0);
        accept();
        idle(1);
        check_eq("stall_overrun", ovr_cnt - base, 0);
`else
        q = {8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00};
        expect_msg("stall", q, 8'h00);
        accept();
        idle(1);
        check_eq("stall_overrun", ovr_cnt - base, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
